// File: rtl/tpiu_frame_decode_if.sv
// Frame-in / byte-out handshake bundle for the TPIU frame decoder.
// The decoder connects through the slave modport; its environment uses master.
interface tpiu_frame_decode_if;
    logic [127:0] PacketIn;
    logic         PackAvail;
    logic         PackAvailAck;
    logic         sync;
    logic [7:0]   dataOut;
    logic [6:0]   streamOut;
    logic         dataValid;
    logic         dataReady;

    modport slave (
        input  PacketIn, PackAvail, sync, dataReady,
        output PackAvailAck, dataOut, streamOut, dataValid
    );

    modport master (
        output PacketIn, PackAvail, sync, dataReady,
        input  PackAvailAck, dataOut, streamOut, dataValid
    );
endinterface

// File: rtl/tpiu_frame_decode.sv
// Decodes captured 128-bit TPIU frames into a stream-tagged byte stream,
// one byte position per clock, with immediate and delayed ID changes.
module tpiu_frame_decode #(
    parameter bit DROP_NULL = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    tpiu_frame_decode_if.slave bus,
    output logic [CNT_W-1:0]   frameCnt,
    output logic [CNT_W-1:0]   dropCnt,
    output logic [CNT_W-1:0]   idChgCnt
);
    typedef enum logic {IDLE, DECODE} state_t;

    state_t           state, stateNxt;
    logic [127:0]     frameReg;
    logic [3:0]       idx, idxNxt;
    logic             armed, armedNxt;
    logic             ack, ackNxt;
    logic [6:0]       curId, curIdNxt;
    logic [6:0]       pendId, pendIdNxt;
    logic             pendV, pendVNxt;
    logic [7:0]       dOut, dOutNxt;
    logic [6:0]       sOut, sOutNxt;
    logic             vld, vldNxt;
    logic [CNT_W-1:0] frameNxt, dropNxt, chgNxt;

    logic             stall, take;
    logic [7:0]       curByte, dataByte;
    logic             auxBit, isChg;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign stall    = vld & ~bus.dataReady;
    // A new frame may only be taken once any pending output byte has been accepted.
    assign take     = (state == IDLE) & bus.PackAvail & armed & ~stall;
    assign curByte  = frameReg[{idx, 3'b000} +: 8];
    assign auxBit   = frameReg[{4'b1111, idx[3:1]}];
    assign isChg    = ~idx[0] & curByte[0];
    assign dataByte = idx[0] ? curByte : {curByte[7:1], auxBit};

    always_comb begin
        stateNxt  = state;
        idxNxt    = idx;
        armedNxt  = armed | ~bus.PackAvail;
        ackNxt    = 1'b0;
        curIdNxt  = curId;
        pendIdNxt = pendId;
        pendVNxt  = pendV;
        dOutNxt   = dOut;
        sOutNxt   = sOut;
        vldNxt    = vld;
        frameNxt  = frameCnt;
        dropNxt   = dropCnt;
        chgNxt    = idChgCnt;

        if (take) begin
            armedNxt = 1'b0;
            ackNxt   = 1'b1;
            if (bus.sync) begin
                stateNxt = DECODE;
                idxNxt   = 4'd0;
                frameNxt = satInc(frameCnt);
            end else begin
                dropNxt  = satInc(dropCnt);
            end
        end

        if (!stall) vldNxt = 1'b0;

        if (state == DECODE && !stall) begin
            if (isChg) begin
                chgNxt = satInc(idChgCnt);
                if (auxBit) begin
                    pendIdNxt = curByte[7:1];
                    pendVNxt  = 1'b1;
                end else begin
                    curIdNxt  = curByte[7:1];
                    pendVNxt  = 1'b0;
                end
            end else begin
                if (!(DROP_NULL && curId == 7'd0)) begin
                    dOutNxt = dataByte;
                    sOutNxt = curId;
                    vldNxt  = 1'b1;
                end
                // A delayed ID takes effect only after the data byte that follows it.
                if (pendV) begin
                    curIdNxt = pendId;
                    pendVNxt = 1'b0;
                end
            end
            if (idx == 4'd14) stateNxt = IDLE;
            else              idxNxt   = idx + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= '0;
            armed    <= 1'b1;
            ack      <= 1'b0;
            curId    <= '0;
            pendId   <= '0;
            pendV    <= 1'b0;
            dOut     <= '0;
            sOut     <= '0;
            vld      <= 1'b0;
            frameCnt <= '0;
            dropCnt  <= '0;
            idChgCnt <= '0;
        end else begin
            state    <= stateNxt;
            idx      <= idxNxt;
            armed    <= armedNxt;
            ack      <= ackNxt;
            curId    <= curIdNxt;
            pendId   <= pendIdNxt;
            pendV    <= pendVNxt;
            dOut     <= dOutNxt;
            sOut     <= sOutNxt;
            vld      <= vldNxt;
            frameCnt <= frameNxt;
            dropCnt  <= dropNxt;
            idChgCnt <= chgNxt;
        end
    end

    always_ff @(posedge clk) begin
        if (take) frameReg <= bus.PacketIn;
    end

    assign bus.PackAvailAck = ack;
    assign bus.dataOut      = dOut;
    assign bus.streamOut    = sOut;
    assign bus.dataValid    = vld;
endmodule
